// File: rtl/cluster_tx_scheduler_if.sv
// Bus bundle for cluster_tx_scheduler: per-crossing cluster snapshot inputs,
// link handshake and status outputs. master = producer/testbench, slave = scheduler.
interface cluster_tx_scheduler_if #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          bx_strobe;
    logic [13:0]   cluster0;
    logic [13:0]   cluster1;
    logic [13:0]   cluster2;
    logic [13:0]   cluster3;
    logic [13:0]   cluster4;
    logic [13:0]   cluster5;
    logic [13:0]   cluster6;
    logic [13:0]   cluster7;
    logic          overflow_in;
    logic          clear_counters;
    logic          link_ready;
    logic          tx_valid;
    logic [15:0]   tx_data;
    logic [CW-1:0] fifo_count;
    logic [CNT_W-1:0] drop_count;
    logic          overflow_out;

    modport master (
        output bx_strobe, cluster0, cluster1, cluster2, cluster3,
               cluster4, cluster5, cluster6, cluster7,
               overflow_in, clear_counters, link_ready,
        input  tx_valid, tx_data, fifo_count, drop_count, overflow_out
    );

    modport slave (
        input  bx_strobe, cluster0, cluster1, cluster2, cluster3,
               cluster4, cluster5, cluster6, cluster7,
               overflow_in, clear_counters, link_ready,
        output tx_valid, tx_data, fifo_count, drop_count, overflow_out
    );
endinterface

// File: rtl/cluster_tx_scheduler.sv
// Serialises the 8 per-crossing packer clusters into a show-ahead FIFO feeding the link.
// Optional bunch-crossing tag in tx_data[15:14]: define CLUSTER_TX_SCHEDULER_BX_TAG_EN.
module cluster_tx_scheduler #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input logic                   clock4x,
    input logic                   global_reset,
    cluster_tx_scheduler_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
`ifdef CLUSTER_TX_SCHEDULER_BX_TAG_EN
    localparam int unsigned EW = 16;
`else
    localparam int unsigned EW = 14;
`endif

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    state_t           r_state;
    logic [7:0]       r_mask;
    logic [13:0]      r_snap [8];
    logic [EW-1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_tx_valid;
    logic [CNT_W-1:0] r_drop;
    logic             r_ovf;
`ifdef CLUSTER_TX_SCHEDULER_BX_TAG_EN
    logic [1:0]       r_tag;
    logic [1:0]       r_snap_tag;
`endif

    logic [13:0]      w_cluster [8];
    logic [7:0]       w_new_mask;
    logic [2:0]       w_sel;
    logic [3:0]       w_pop;
    logic [7:0]       w_rest;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;
    logic [CW-1:0]    w_count_nxt;
    logic [CNT_W:0]   w_drop_sum;
    logic [CNT_W-1:0] w_drop_sat;
    logic [EW-1:0]    w_wr_word;

    assign w_cluster[0] = bus.cluster0;
    assign w_cluster[1] = bus.cluster1;
    assign w_cluster[2] = bus.cluster2;
    assign w_cluster[3] = bus.cluster3;
    assign w_cluster[4] = bus.cluster4;
    assign w_cluster[5] = bus.cluster5;
    assign w_cluster[6] = bus.cluster6;
    assign w_cluster[7] = bus.cluster7;

    // Address 0x7FF marks an empty slot
    always_comb begin
        w_new_mask = '0;
        for (int i = 0; i < 8; i++) begin
            w_new_mask[i] = (w_cluster[i][10:0] != 11'h7FF);
        end
    end

    // Lowest pending slot and count of slots still waiting
    always_comb begin
        w_sel = '0;
        w_pop = '0;
        for (int i = 7; i >= 0; i--) begin
            if (r_mask[i]) w_sel = 3'(i);
        end
        for (int i = 0; i < 8; i++) begin
            w_pop = w_pop + 4'(r_mask[i]);
        end
    end

    assign w_rest      = r_mask & ~(8'(1) << w_sel);
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    // A strobe cycle only re-snapshots; leftovers of the old crossing are dropped
    assign w_wr        = (r_state == S_DRAIN) && !bus.bx_strobe && !w_full;
    assign w_rd        = r_tx_valid && bus.link_ready;
    assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_rd);
    assign w_drop_sum  = {1'b0, r_drop} + (CNT_W+1)'(w_pop);
    assign w_drop_sat  = w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];

`ifdef CLUSTER_TX_SCHEDULER_BX_TAG_EN
    assign w_wr_word   = {r_snap_tag, r_snap[w_sel]};
    assign bus.tx_data = r_mem[r_rd_ptr];
`else
    assign w_wr_word   = r_snap[w_sel];
    assign bus.tx_data = {2'b00, r_mem[r_rd_ptr]};
`endif

    assign bus.tx_valid     = r_tx_valid;
    assign bus.fifo_count   = r_count;
    assign bus.drop_count   = r_drop;
    assign bus.overflow_out = r_ovf;

    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) begin
            r_state    <= S_IDLE;
            r_mask     <= '0;
            r_snap     <= '{default: '0};
            r_mem      <= '{default: '0};
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tx_valid <= 1'b0;
            r_drop     <= '0;
            r_ovf      <= 1'b0;
`ifdef CLUSTER_TX_SCHEDULER_BX_TAG_EN
            r_tag      <= '0;
            r_snap_tag <= '0;
`endif
        end else begin
            if (bus.bx_strobe) begin
                r_snap  <= w_cluster;
                r_mask  <= w_new_mask;
                r_state <= (w_new_mask != '0) ? S_DRAIN : S_IDLE;
`ifdef CLUSTER_TX_SCHEDULER_BX_TAG_EN
                r_snap_tag <= r_tag;
                r_tag      <= r_tag + 2'd1;
`endif
            end else if (w_wr) begin
                r_mask <= w_rest;
                if (w_rest == '0) r_state <= S_IDLE;
            end

            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_wr_word;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count    <= w_count_nxt;
            r_tx_valid <= (w_count_nxt != '0);

            // Clear wins over any same-cycle drop or overflow
            if (bus.clear_counters) begin
                r_drop <= '0;
                r_ovf  <= 1'b0;
            end else if (bus.bx_strobe) begin
                r_drop <= w_drop_sat;
                if ((w_pop != '0) || bus.overflow_in) r_ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cluster_tx_scheduler.sv
// Self-checking bench for cluster_tx_scheduler: directed scenarios plus random traffic
// against a queue-based model of snapshot, FIFO and drop accounting.
module tb_cluster_tx_scheduler;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned DROP_MAX = (1 << CNT_W) - 1;
`ifdef CLUSTER_TX_SCHEDULER_BX_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cluster_tx_scheduler_if #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    cluster_tx_scheduler #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock4x      (clk),
        .global_reset (rst),
        .bus          (bus.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [13:0] cl [8];

    int unsigned m_fifo [$];
    int unsigned m_pend [$];
    int unsigned m_tag;
    int unsigned m_drop;
    bit          m_ovf;
    logic [15:0] q_seen [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned mk_word(input int unsigned tag, input logic [13:0] c);
        return TAG_EN ? (((tag % 4) << 14) | 32'(c)) : 32'(c);
    endfunction

    function automatic logic [13:0] rnd_valid();
        return {3'($urandom), 11'($urandom_range(0, 2046))};
    endfunction

    task automatic cl_invalid();
        for (int i = 0; i < 8; i++) cl[i] = 14'h07FF;
    endtask

    task automatic drive_cl();
        bus.cluster0 = cl[0]; bus.cluster1 = cl[1];
        bus.cluster2 = cl[2]; bus.cluster3 = cl[3];
        bus.cluster4 = cl[4]; bus.cluster5 = cl[5];
        bus.cluster6 = cl[6]; bus.cluster7 = cl[7];
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_pend.delete();
        m_tag  = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_model();
        check_val("tx_valid", 32'(bus.tx_valid), 32'(m_fifo.size() != 0));
        check_val("fifo_count", 32'(bus.fifo_count), 32'(m_fifo.size()));
        if (m_fifo.size() != 0) check_val("tx_data", 32'(bus.tx_data), m_fifo[0]);
        check_val("drop_count", 32'(bus.drop_count), m_drop);
        check_val("overflow_out", 32'(bus.overflow_out), 32'(m_ovf));
    endtask

    // One clock: model follows the inputs held since the last falling edge
    task automatic step();
        bit do_rd, do_wr, stb, ovf_in, clr, rst_s;
        int unsigned pc;
        stb    = bus.bx_strobe;
        ovf_in = bus.overflow_in;
        clr    = bus.clear_counters;
        rst_s  = rst;
        do_rd  = (m_fifo.size() != 0) && bus.link_ready;
        do_wr  = !stb && (m_pend.size() != 0) && (m_fifo.size() < DEPTH);
        if (bus.tx_valid && bus.link_ready) q_seen.push_back(bus.tx_data);
        @(posedge clk);
        if (rst_s) begin
            model_reset();
        end else begin
            if (do_rd) void'(m_fifo.pop_front());
            if (do_wr) m_fifo.push_back(m_pend.pop_front());
            if (stb) begin
                pc     = m_pend.size();
                m_drop = (m_drop + pc > DROP_MAX) ? DROP_MAX : m_drop + pc;
                if (pc != 0 || ovf_in) m_ovf = 1'b1;
                m_pend.delete();
                for (int i = 0; i < 8; i++)
                    if (cl[i][10:0] != 11'h7FF) m_pend.push_back(mk_word(m_tag, cl[i]));
                m_tag++;
            end
            if (clr) begin
                m_drop = 0;
                m_ovf  = 1'b0;
            end
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic do_strobe();
        drive_cl();
        bus.bx_strobe = 1'b1;
        step();
        bus.bx_strobe   = 1'b0;
        bus.overflow_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_val("rst_tx_valid", 32'(bus.tx_valid), 0);
        check_val("rst_tx_data", 32'(bus.tx_data), 0);
        check_val("rst_fifo_count", 32'(bus.fifo_count), 0);
        check_val("rst_drop_count", 32'(bus.drop_count), 0);
        check_val("rst_overflow", 32'(bus.overflow_out), 0);
        @(negedge clk);
        step();
        rst = 1'b0;
    endtask

    task automatic run_basic();
        bus.link_ready = 1'b1;
        cl_invalid();
        cl[1] = 14'h0012; cl[4] = 14'h0234; cl[6] = 14'h05FF;
        do_strobe();
        check_val("basic_n1_valid", 32'(bus.tx_valid), 0);
        step();
        check_val("basic_n2_valid", 32'(bus.tx_valid), 1);
        check_val("basic_n2_data", 32'(bus.tx_data), 32'h0012);
        step();
        check_val("basic_n3_data", 32'(bus.tx_data), 32'h0234);
        step();
        check_val("basic_n4_data", 32'(bus.tx_data), 32'h05FF);
        step();
        check_val("basic_n5_valid", 32'(bus.tx_valid), 0);
        step();
        check_val("basic_n6_valid", 32'(bus.tx_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned rem, k;
        logic [15:0] exp_tag [4];
        rst = 1'b1;
        bus.bx_strobe = 1'b0; bus.overflow_in = 1'b0;
        bus.clear_counters = 1'b0; bus.link_ready = 1'b1;
        cl_invalid();
        drive_cl();
        model_reset();
        @(negedge clk);
        do_reset();

        run_basic();

        // Reset mid-drain with five entries queued
        bus.link_ready = 1'b0;
        for (int i = 0; i < 8; i++) cl[i] = rnd_valid();
        do_strobe();
        for (int i = 0; i < 20 && m_fifo.size() != 5; i++) step();
        check_val("midrst_fill", 32'(bus.fifo_count), 5);
        do_reset();
        check_val("midrst_drop", 32'(bus.drop_count), 0);
        run_basic();

        // All-invalid strobe still advances the tag
        do_reset();
        cl_invalid();
        do_strobe();
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("allinv_no_valid", 32'(bus.tx_valid), 0);
        end
        cl[0] = 14'h0001;
        do_strobe();
        step();
        check_val("allinv_next_tag", 32'(bus.tx_data), TAG_EN ? 32'h4001 : 32'h0001);

        // Four strobes carry consecutive tags
        do_reset();
        exp_tag[0] = 16'h0001;
        exp_tag[1] = TAG_EN ? 16'h4001 : 16'h0001;
        exp_tag[2] = TAG_EN ? 16'h8001 : 16'h0001;
        exp_tag[3] = TAG_EN ? 16'hC001 : 16'h0001;
        q_seen.delete();
        for (int s = 0; s < 4; s++) begin
            cl_invalid();
            cl[0] = 14'h0001;
            do_strobe();
            repeat (3) step();
        end
        repeat (3) step();
        check_val("tag_seq_len", 32'(q_seen.size()), 4);
        for (int s = 0; s < 4 && s < q_seen.size(); s++)
            check_val("tag_seq_word", 32'(q_seen[s]), 32'(exp_tag[s]));

        // Stalled link: FIFO fills, each strobe drops 5 leftovers
        do_reset();
        bus.link_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c % 4 == 0) begin
                for (int i = 0; i < 8; i++) cl[i] = rnd_valid();
                do_strobe();
            end else begin
                step();
            end
        end
        repeat (16) step();
        check_val("full_count", 32'(bus.fifo_count), 16);
        check_val("full_drop", 32'(bus.drop_count), 20);
        check_val("full_ovf", 32'(bus.overflow_out), 1);
        for (int i = 0; i < 8; i++) cl[i] = rnd_valid();
        do_strobe();
        check_val("full_drop2", 32'(bus.drop_count), 24);
        check_val("full_count2", 32'(bus.fifo_count), 16);

        // Drive the drop counter to 0xFFFE, then saturate
        while (m_drop + m_pend.size() < 32'hFFFE) begin
            rem = 32'hFFFE - m_drop - m_pend.size();
            k   = (rem > 8) ? 8 : rem;
            cl_invalid();
            for (int i = 0; i < 8; i++) if (i < k) cl[i] = rnd_valid();
            do_strobe();
        end
        cl_invalid();
        cl[0] = rnd_valid(); cl[5] = rnd_valid();
        do_strobe();
        check_val("sat_fffe", 32'(bus.drop_count), 32'hFFFE);
        cl_invalid();
        cl[2] = rnd_valid();
        do_strobe();
        check_val("sat_ffff", 32'(bus.drop_count), 32'hFFFF);
        cl_invalid();
        do_strobe();
        check_val("sat_hold", 32'(bus.drop_count), 32'hFFFF);
        bus.clear_counters = 1'b1;
        step();
        bus.clear_counters = 1'b0;
        check_val("clr_drop", 32'(bus.drop_count), 0);
        check_val("clr_ovf", 32'(bus.overflow_out), 0);
        for (int i = 0; i < 8; i++) cl[i] = rnd_valid();
        do_strobe();
        bus.clear_counters = 1'b1;
        do_strobe();
        bus.clear_counters = 1'b0;
        check_val("clr_prio_drop", 32'(bus.drop_count), 0);
        check_val("clr_prio_ovf", 32'(bus.overflow_out), 0);

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.link_ready     = ($urandom_range(0, 3) != 0);
            bus.clear_counters = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < 8; i++)
                    cl[i] = ($urandom_range(0, 9) < 6) ? rnd_valid() : {3'($urandom), 11'h7FF};
                bus.overflow_in = ($urandom_range(0, 7) == 0);
                do_strobe();
            end else begin
                step();
            end
        end
        bus.clear_counters = 1'b0;
        bus.link_ready     = 1'b1;
        repeat (30) step();
        check_val("drain_empty", 32'(bus.tx_valid), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
